// File: rtl/iq_cut_sat_agc_pkg.sv
// Shared constants, width helpers and control states for the I/Q requantiser.
package iq_cut_pkg;

    function automatic int max_shift(input int in_w, input int out_w);
        return in_w - out_w;
    endfunction

    function automatic int shift_w(input int in_w, input int out_w);
        return $clog2(in_w - out_w + 1);
    endfunction

    function automatic longint sat_hi(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] CLOSE = 1'b1;

endpackage

// File: rtl/iq_cut_sat_agc_if.sv
// Streaming I/Q bus: input beat handshake plus requantised output beat.
interface iq_cut_sat_agc_if
    import iq_cut_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    localparam int SHIFT_W = shift_w(IN_W, OUT_W);

    logic [IN_W-1:0]    data_i;
    logic [IN_W-1:0]    data_q;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [OUT_W-1:0]   data_out_i;
    logic [OUT_W-1:0]   data_out_q;
    logic               out_valid;
    logic               out_last;
    logic               out_sat;
    logic               out_ready;
    logic [SHIFT_W-1:0] gain_used;

    modport master (
        output data_i, data_q, in_valid, in_last, out_ready,
        input  in_ready, data_out_i, data_out_q, out_valid,
        input  out_last, out_sat, gain_used
    );

    modport slave (
        input  data_i, data_q, in_valid, in_last, out_ready,
        output in_ready, data_out_i, data_out_q, out_valid,
        output out_last, out_sat, gain_used
    );
endinterface

// File: rtl/iq_cut_sat_agc_lzc.sv
// Leading-zero count of the peak mask, clamped to the largest usable gain.
module iq_headroom_lzc #(
    parameter int W   = 31,
    parameter int MAX = 16,
    parameter int OW  = 5
) (
    input  logic [W-1:0]  v,
    output logic [OW-1:0] cnt
);
    int   n;
    logic found;

    always_comb begin
        n     = W;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = W - 1 - i;
                found = 1'b1;
            end
        end
        cnt = (n > MAX) ? OW'(MAX) : OW'(n);
    end
endmodule

// File: rtl/iq_cut_sat_agc.sv
// I/Q requantiser with saturation, frame statistics and auto gain.
// Define IQ_CUT_ROUND_EN for round-half-up; otherwise floor.
module iq_cut_sat_agc
    import iq_cut_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16,
    localparam int MAX_SHIFT = max_shift(IN_W, OUT_W),
    localparam int SHIFT_W   = shift_w(IN_W, OUT_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               auto_en,
    input  logic [SHIFT_W-1:0] cut_gain,
    iq_cut_sat_agc_if.slave    bus,
    output logic               frame_done,
    output logic [CNT_W-1:0]   frame_sat_cnt,
    output logic [SHIFT_W-1:0] frame_gain
);
    localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'(sat_hi(OUT_W));
    localparam logic signed [IN_W:0] SAT_LO = (IN_W+1)'(sat_lo(OUT_W));

    logic [0:0]         state;
    logic [SHIFT_W-1:0] auto_gain;
    logic [SHIFT_W-1:0] g_eff;
    logic [SHIFT_W-1:0] sh;
    logic [SHIFT_W-1:0] lzc;
    logic [IN_W-2:0]    mask;
    logic [IN_W-2:0]    mask_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [OUT_W:0]     rq_i;
    logic [OUT_W:0]     rq_q;
    logic               acc;
    logic               sat;

    // Result is {saturated, sample}.
    function automatic logic [OUT_W:0] requant(
        input logic [IN_W-1:0]    x,
        input logic [SHIFT_W-1:0] s
    );
        logic signed [IN_W:0] v;
        logic signed [IN_W:0] y;
        v = signed'({x[IN_W-1], x});
`ifdef IQ_CUT_ROUND_EN
        if (s != '0)
            v = v + signed'((IN_W+1)'(1) << (s - 1'b1));
`endif
        y = v >>> s;
        if (y > SAT_HI)
            return {1'b1, SAT_HI[OUT_W-1:0]};
        if (y < SAT_LO)
            return {1'b1, SAT_LO[OUT_W-1:0]};
        return {1'b0, y[OUT_W-1:0]};
    endfunction

    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign acc          = bus.in_valid & bus.in_ready;
    assign frame_done   = (state == CLOSE);

    always_comb begin
        g_eff = cut_gain;
        if (auto_en)
            g_eff = auto_gain;
        else if (cut_gain > SHIFT_W'(MAX_SHIFT))
            g_eff = SHIFT_W'(MAX_SHIFT);
    end

    assign sh   = SHIFT_W'(MAX_SHIFT) - g_eff;
    assign rq_i = requant(bus.data_i, sh);
    assign rq_q = requant(bus.data_q, sh);
    assign sat  = rq_i[OUT_W] | rq_q[OUT_W];

    // Sign-folded magnitude bits; the last frame sample must be included.
    assign mask_nx = mask
                   | (bus.data_i[IN_W-2:0] ^ {(IN_W-1){bus.data_i[IN_W-1]}})
                   | (bus.data_q[IN_W-2:0] ^ {(IN_W-1){bus.data_q[IN_W-1]}});

    assign cnt_nx = (sat && cnt != '1) ? cnt + 1'b1 : cnt;

    iq_headroom_lzc #(
        .W   (IN_W - 1),
        .MAX (MAX_SHIFT),
        .OW  (SHIFT_W)
    ) u_lzc (
        .v   (mask_nx),
        .cnt (lzc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ACCUM;
            auto_gain      <= '0;
            mask           <= '0;
            cnt            <= '0;
            frame_sat_cnt  <= '0;
            frame_gain     <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.out_sat    <= 1'b0;
            bus.data_out_i <= '0;
            bus.data_out_q <= '0;
            bus.gain_used  <= '0;
        end else begin
            state <= (acc && bus.in_last) ? CLOSE : ACCUM;
            if (bus.in_ready)
                bus.out_valid <= bus.in_valid;
            if (acc) begin
                bus.data_out_i <= rq_i[OUT_W-1:0];
                bus.data_out_q <= rq_q[OUT_W-1:0];
                bus.out_sat    <= sat;
                bus.out_last   <= bus.in_last;
                bus.gain_used  <= g_eff;
                if (bus.in_last) begin
                    mask          <= '0;
                    cnt           <= '0;
                    frame_sat_cnt <= cnt_nx;
                    frame_gain    <= lzc;
                    auto_gain     <= lzc;
                end else begin
                    mask <= mask_nx;
                    cnt  <= cnt_nx;
                end
            end
        end
    end
endmodule
